// File: rtl/parking_occupancy.sv
// Occupancy manager for a 4-spot lot: serves entry/exit requests, allocates the
// lowest free spot, reports free count / full, and drives a timed gate.
module parking_occupancy #(
    parameter int GATE_CYCLES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_entry_req,
    input  logic       i_exit_req,
    input  logic [1:0] i_exit_spot,
    output logic [3:0] o_occupied,
    output logic [2:0] o_free_count,
    output logic       o_full,
    output logic       o_entry_ack,
    output logic [1:0] o_entry_spot,
    output logic       o_entry_reject,
    output logic       o_exit_ack,
    output logic       o_exit_err,
    output logic       o_gate_open
);

    localparam int             CW     = $clog2(GATE_CYCLES + 1);
    localparam logic [CW-1:0]  C_LOAD = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);
    localparam logic [CW-1:0]  C_ZERO = CW'(0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    function automatic logic [1:0] f_lowest_free(input logic [3:0] occ);
        logic [1:0] idx;
        casez (occ)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] f_free_count(input logic [3:0] occ);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, ~occ[i]};
        end
        return cnt;
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_occ;
    logic [2:0]    r_free;
    logic          r_full;
    logic [1:0]    r_spot;
    logic          r_eack;
    logic          r_erej;
    logic          r_xack;
    logic          r_xerr;
    logic          r_gate;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_occ_nxt;
    logic [1:0]    w_spot_nxt;
    logic          w_eack;
    logic          w_erej;
    logic          w_xack;
    logic          w_xerr;
    logic          w_gate_nxt;

    // Next-state and response decode; only IDLE samples requests, exit first.
    // The gate register stays high through the last GATE cycle, which lets the
    // counter hand back to IDLE one edge early so a pending request is served
    // exactly GATE_CYCLES edges after the previous grant.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_occ_nxt   = r_occ;
        w_spot_nxt  = r_spot;
        w_eack      = 1'b0;
        w_erej      = 1'b0;
        w_xack      = 1'b0;
        w_xerr      = 1'b0;
        w_gate_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_exit_req) begin
                    if (r_occ[i_exit_spot]) begin
                        w_occ_nxt[i_exit_spot] = 1'b0;
                        w_xack     = 1'b1;
                        w_gate_nxt = 1'b1;
                        if (GATE_CYCLES > 1) begin
                            w_state_nxt = S_GATE;
                            w_cnt_nxt   = C_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_xerr = 1'b1;
                    end
                end else if (i_entry_req) begin
                    if (!r_full) begin
                        w_spot_nxt            = f_lowest_free(r_occ);
                        w_occ_nxt[w_spot_nxt] = 1'b1;
                        w_eack                = 1'b1;
                        w_gate_nxt            = 1'b1;
                        if (GATE_CYCLES > 1) begin
                            w_state_nxt = S_GATE;
                            w_cnt_nxt   = C_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_erej = 1'b1;
                    end
                end else begin
                    w_gate_nxt = 1'b0;
                end
            end
            S_GATE: begin
                w_gate_nxt = 1'b1;
                if (r_cnt <= C_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = C_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = C_ZERO;
            end
        endcase
    end

    // State and output registers; free count and full track the new occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= C_ZERO;
            r_occ   <= 4'b0000;
            r_free  <= 3'd4;
            r_full  <= 1'b0;
            r_spot  <= 2'd0;
            r_eack  <= 1'b0;
            r_erej  <= 1'b0;
            r_xack  <= 1'b0;
            r_xerr  <= 1'b0;
            r_gate  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_occ   <= w_occ_nxt;
            r_free  <= f_free_count(w_occ_nxt);
            r_full  <= &w_occ_nxt;
            r_spot  <= w_spot_nxt;
            r_eack  <= w_eack;
            r_erej  <= w_erej;
            r_xack  <= w_xack;
            r_xerr  <= w_xerr;
            r_gate  <= w_gate_nxt;
        end
    end

    assign o_occupied     = r_occ;
    assign o_free_count   = r_free;
    assign o_full         = r_full;
    assign o_entry_ack    = r_eack;
    assign o_entry_spot   = r_spot;
    assign o_entry_reject = r_erej;
    assign o_exit_ack     = r_xack;
    assign o_exit_err     = r_xerr;
    assign o_gate_open    = r_gate;

endmodule

// File: tb/tb_parking_occupancy.sv
// Scoreboard bench for parking_occupancy: stimulus pushes expected responses and
// gate-open run lengths; independent monitors pop and compare.
module tb_parking_occupancy;

    typedef struct packed {
        logic [1:0] kind;   // 0 entry_ack, 1 entry_reject, 2 exit_ack, 3 exit_err
        logic [1:0] spot;
        logic [3:0] occ;
        logic [2:0] fc;
        logic       full;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_spot;
    logic [3:0] occupied;
    logic [2:0] free_count;
    logic       full;
    logic       entry_ack;
    logic [1:0] entry_spot;
    logic       entry_reject;
    logic       exit_ack;
    logic       exit_err;
    logic       gate_open;

    exp_t q_resp[$];
    int   q_gate[$];
    int   checks = 0;
    int   errors = 0;

    parking_occupancy #(.GATE_CYCLES(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_entry_req  (entry_req),
        .i_exit_req   (exit_req),
        .i_exit_spot  (exit_spot),
        .o_occupied   (occupied),
        .o_free_count (free_count),
        .o_full       (full),
        .o_entry_ack  (entry_ack),
        .o_entry_spot (entry_spot),
        .o_entry_reject(entry_reject),
        .o_exit_ack   (exit_ack),
        .o_exit_err   (exit_err),
        .o_gate_open  (gate_open)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] kind, input logic [1:0] spot,
                                input logic [3:0] occ, input logic [2:0] fc,
                                input logic f);
        exp_t e;
        e.kind = kind; e.spot = spot; e.occ = occ; e.fc = fc; e.full = f;
        return e;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return entry_ack | entry_reject;
            1:       return exit_ack | exit_err;
            default: return ~gate_open;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_for(input int which);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < 100);
        checks++;
        if (!sig(which)) begin
            errors++;
            $display("FAIL timeout waiting on event %0d: got 0 expected 1", which);
        end
    endtask

    task automatic do_entry(input exp_t e, input int gate_len);
        q_resp.push_back(e);
        if (gate_len > 0) q_gate.push_back(gate_len);
        entry_req = 1'b1;
        wait_for(0);
        entry_req = 1'b0;
        wait_for(2);
    endtask

    task automatic do_exit(input logic [1:0] spot, input exp_t e, input int gate_len);
        q_resp.push_back(e);
        if (gate_len > 0) q_gate.push_back(gate_len);
        exit_spot = spot;
        exit_req  = 1'b1;
        wait_for(1);
        exit_req  = 1'b0;
        wait_for(2);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_occupied"},   {4'h0, occupied},   8'h00);
        chk({tag, "_free_count"}, {5'h0, free_count}, 8'h04);
        chk({tag, "_full"},       {7'h0, full},       8'h00);
        chk({tag, "_gate_open"},  {7'h0, gate_open},  8'h00);
        chk({tag, "_entry_spot"}, {6'h0, entry_spot}, 8'h00);
        chk({tag, "_pulses"}, {4'h0, entry_ack, entry_reject, exit_ack, exit_err}, 8'h00);
    endtask

    // Response monitor: every pulse must match the head of the scoreboard.
    initial begin
        exp_t act;
        exp_t e;
        int   np;
        forever begin
            @(negedge clk);
            np = int'(entry_ack) + int'(entry_reject) + int'(exit_ack) + int'(exit_err);
            if (!rst && np > 0) begin
                act.kind = entry_ack ? 2'd0 : entry_reject ? 2'd1 : exit_ack ? 2'd2 : 2'd3;
                act.spot = entry_spot;
                act.occ  = occupied;
                act.fc   = free_count;
                act.full = full;
                checks++;
                if (np > 1) begin
                    errors++;
                    $display("FAIL resp_multi: got %0d pulses expected 1", np);
                end else if (q_resp.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got %h expected none", act);
                end else begin
                    e = q_resp.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL resp kind/spot/occ/fc/full: got %0d/%0d/%b/%0d/%0d expected %0d/%0d/%b/%0d/%0d",
                                 act.kind, act.spot, act.occ, act.fc, act.full,
                                 e.kind, e.spot, e.occ, e.fc, e.full);
                    end
                end
            end
        end
    end

    // Gate monitor: length of every gate_open high run against the scoreboard.
    initial begin
        int run;
        int e;
        run = 0;
        forever begin
            @(negedge clk);
            if (gate_open) begin
                run++;
            end else if (run > 0) begin
                checks++;
                if (q_gate.size() == 0) begin
                    errors++;
                    $display("FAIL gate_unexpected: got run %0d expected none", run);
                end else begin
                    e = q_gate.pop_front();
                    if (run != e) begin
                        errors++;
                        $display("FAIL gate_len: got %0d expected %0d", run, e);
                    end
                end
                run = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_spot = 2'd0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // 1: fill the lot
        do_entry(mk(2'd0, 2'd0, 4'b0001, 3'd3, 1'b0), 8);
        do_entry(mk(2'd0, 2'd1, 4'b0011, 3'd2, 1'b0), 8);
        do_entry(mk(2'd0, 2'd2, 4'b0111, 3'd1, 1'b0), 8);
        do_entry(mk(2'd0, 2'd3, 4'b1111, 3'd0, 1'b1), 8);

        // 2: full lot, entry held three IDLE cycles
        for (int i = 0; i < 3; i++) q_resp.push_back(mk(2'd1, 2'd3, 4'b1111, 3'd0, 1'b1));
        entry_req = 1'b1;
        repeat (3) @(negedge clk);
        entry_req = 1'b0;
        repeat (2) @(negedge clk);

        // 3: free spot 2, next entry reuses it
        do_exit(2'd2, mk(2'd2, 2'd3, 4'b1011, 3'd1, 1'b0), 8);
        do_entry(mk(2'd0, 2'd2, 4'b1111, 3'd0, 1'b1), 8);

        // 4: reach 0101, then exit an empty spot
        do_exit(2'd1, mk(2'd2, 2'd2, 4'b1101, 3'd1, 1'b0), 8);
        do_exit(2'd3, mk(2'd2, 2'd2, 4'b0101, 3'd2, 1'b0), 8);
        do_exit(2'd1, mk(2'd3, 2'd2, 4'b0101, 3'd2, 1'b0), 0);
        do_entry(mk(2'd0, 2'd1, 4'b0111, 3'd1, 1'b0), 8);
        do_entry(mk(2'd0, 2'd3, 4'b1111, 3'd0, 1'b1), 8);

        // 5: simultaneous exit (spot 0) and entry while full
        q_resp.push_back(mk(2'd2, 2'd3, 4'b1110, 3'd1, 1'b0));
        q_resp.push_back(mk(2'd0, 2'd0, 4'b1111, 3'd0, 1'b1));
        q_gate.push_back(16);
        exit_spot = 2'd0;
        exit_req  = 1'b1;
        entry_req = 1'b1;
        wait_for(1);
        exit_req  = 1'b0;
        wait_for(0);
        entry_req = 1'b0;
        wait_for(2);

        // 6: reset in the 3rd cycle of a gate period with occupied=0011
        do_exit(2'd3, mk(2'd2, 2'd0, 4'b0111, 3'd1, 1'b0), 8);
        q_resp.push_back(mk(2'd2, 2'd0, 4'b0011, 3'd2, 1'b0));
        q_gate.push_back(3);
        exit_spot = 2'd2;
        exit_req  = 1'b1;
        wait_for(1);
        exit_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midgate");
        rst = 1'b0;
        @(negedge clk);
        do_entry(mk(2'd0, 2'd0, 4'b0001, 3'd3, 1'b0), 8);

        repeat (3) @(negedge clk);
        chk("resp_queue_left", 8'(q_resp.size()), 8'h00);
        chk("gate_queue_left", 8'(q_gate.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
